// File: rtl/dcache_port_arbiter.sv
// Shares the single data-cache port between speculative loads and committed stores.
// Loads win arbitration unless a store has been starved for STARVE_LIMIT cycles.
module dcache_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        squash_i,
    input  logic        ld_req_i,
    input  logic [31:0] ld_addr_i,
    input  logic [2:0]  ld_size_i,
    output logic        ld_grant_o,
    output logic        ld_valid_o,
    output logic [31:0] ld_data_o,
    input  logic        st_req_i,
    input  logic [31:0] st_addr_i,
    input  logic [2:0]  st_size_i,
    input  logic [31:0] st_data_i,
    output logic        st_grant_o,
    output logic        st_done_o,
    output logic [1:0]  mem_cmd_o,
    output logic [31:0] mem_addr_o,
    output logic [2:0]  mem_size_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_STORE = 2'b10;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        LD_BUSY,
        ST_BUSY,
        DRAIN
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              ld_valid_q;
    logic [31:0]       ld_data_q;
    logic              st_done_q;
    logic [1:0]        cmd_q;
    logic [31:0]       addr_q;
    logic [2:0]        size_q;
    logic [31:0]       wdata_q;
    logic              ld_elig;
    logic              st_win;
    logic              ld_win;

    // Grants are decided in the request cycle so the requester can drop req at once.
    always_comb begin
        ld_elig = ld_req_i && !squash_i;
        st_win  = rst_ni && (state_q == IDLE) && st_req_i
                  && ((cnt_q == LIMIT) || !ld_elig);
        ld_win  = rst_ni && (state_q == IDLE) && ld_elig && !st_win;
        cnt_d   = cnt_q;
        if (st_win) begin
            cnt_d = '0;
        end else if (st_req_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ld_valid_q <= 1'b0;
            ld_data_q  <= '0;
            st_done_q  <= 1'b0;
            cmd_q      <= CMD_NONE;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            ld_valid_q <= 1'b0;
            st_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (st_win) begin
                        cmd_q   <= CMD_STORE;
                        addr_q  <= st_addr_i;
                        size_q  <= st_size_i;
                        wdata_q <= st_data_i;
                        state_q <= ST_BUSY;
                    end else if (ld_win) begin
                        cmd_q   <= CMD_LOAD;
                        addr_q  <= ld_addr_i;
                        size_q  <= ld_size_i;
                        wdata_q <= '0;
                        state_q <= LD_BUSY;
                    end
                end
                LD_BUSY: begin
                    if (mem_ack_i) begin
                        cmd_q      <= CMD_NONE;
                        addr_q     <= '0;
                        size_q     <= '0;
                        wdata_q    <= '0;
                        ld_valid_q <= !squash_i;
                        if (!squash_i) begin
                            ld_data_q <= mem_rdata_i;
                        end
                        state_q    <= IDLE;
                    end else if (squash_i) begin
                        // Memory still owes an ack; swallow it in DRAIN.
                        state_q <= DRAIN;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack_i) begin
                        cmd_q     <= CMD_NONE;
                        addr_q    <= '0;
                        size_q    <= '0;
                        wdata_q   <= '0;
                        st_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                DRAIN: begin
                    if (mem_ack_i) begin
                        cmd_q   <= CMD_NONE;
                        addr_q  <= '0;
                        size_q  <= '0;
                        wdata_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ld_grant_o  = ld_win;
    assign st_grant_o  = st_win;
    assign ld_valid_o  = ld_valid_q;
    assign ld_data_o   = ld_data_q;
    assign st_done_o   = st_done_q;
    assign mem_cmd_o   = cmd_q;
    assign mem_addr_o  = addr_q;
    assign mem_size_o  = size_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: transaction-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_dcache_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        squash = 1'b0;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [2:0]  ld_size = '0;
    logic        ld_grant;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        st_req = 1'b0;
    logic [31:0] st_addr = '0;
    logic [2:0]  st_size = '0;
    logic [31:0] st_data = '0;
    logic        st_grant;
    logic        st_done;
    logic [1:0]  mem_cmd;
    logic [31:0] mem_addr;
    logic [2:0]  mem_size;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    dcache_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk_i(clk), .rst_ni(rst_n), .squash_i(squash),
        .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_size_i(ld_size),
        .ld_grant_o(ld_grant), .ld_valid_o(ld_valid), .ld_data_o(ld_data),
        .st_req_i(st_req), .st_addr_i(st_addr), .st_size_i(st_size),
        .st_data_i(st_data), .st_grant_o(st_grant), .st_done_o(st_done),
        .mem_cmd_o(mem_cmd), .mem_addr_o(mem_addr), .mem_size_o(mem_size),
        .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: one outstanding access, a kill flag for squashed loads,
    // and the number of cycles the store has been kept waiting.
    bit        m_out = 0;
    bit        m_st = 0;
    bit        m_kill = 0;
    bit [31:0] m_addr = 0;
    bit [2:0]  m_size = 0;
    bit [31:0] m_wdata = 0;
    int        m_starve = 0;
    bit        e_ldv = 0;
    bit        e_std = 0;
    bit [31:0] e_ldd = 0;
    bit        p_ld = 0;
    bit        p_st = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out <= 0; m_st <= 0; m_kill <= 0;
            m_addr <= 0; m_size <= 0; m_wdata <= 0;
            m_starve <= 0; e_ldv <= 0; e_std <= 0; e_ldd <= 0;
            p_ld <= 0; p_st <= 0;
        end else begin
            automatic bit le = ld_req && !squash;
            automatic bit sw = !m_out && st_req && (m_starve == LIMIT || !le);
            automatic bit lw = !m_out && le && !sw;
            if (p_ld) chk("proto_ld_held", 32'(ld_req), 32'd1);
            if (p_st) chk("proto_st_held", 32'(st_req), 32'd1);
            p_ld <= ld_req && !lw && !squash;
            p_st <= st_req && !sw;
            e_ldv <= 0;
            e_std <= 0;
            if (m_out) begin
                if (mem_ack) begin
                    m_out <= 0;
                    m_kill <= 0;
                    if (m_st) e_std <= 1;
                    else if (!m_kill && !squash) begin
                        e_ldv <= 1;
                        e_ldd <= mem_rdata;
                    end
                end else if (!m_st && squash) begin
                    m_kill <= 1;
                end
            end else if (sw) begin
                m_out <= 1; m_st <= 1;
                m_addr <= st_addr; m_size <= st_size; m_wdata <= st_data;
            end else if (lw) begin
                m_out <= 1; m_st <= 0;
                m_addr <= ld_addr; m_size <= ld_size; m_wdata <= 0;
            end
            if (sw) m_starve <= 0;
            else if (st_req && m_starve < LIMIT) m_starve <= m_starve + 1;
        end
    end

    always @(negedge clk) begin
        automatic bit le = ld_req && !squash;
        automatic bit sw = rst_n && !m_out && st_req && (m_starve == LIMIT || !le);
        automatic bit lw = rst_n && !m_out && le && !sw;
        automatic bit [1:0] ecmd = !m_out ? 2'd0 : (m_st ? 2'd2 : 2'd1);
        chk("m_ld_grant", 32'(ld_grant), 32'(lw));
        chk("m_st_grant", 32'(st_grant), 32'(sw));
        chk("m_ld_valid", 32'(ld_valid), 32'(e_ldv));
        chk("m_ld_data", ld_data, e_ldd);
        chk("m_st_done", 32'(st_done), 32'(e_std));
        chk("m_mem_cmd", 32'(mem_cmd), 32'(ecmd));
        chk("m_mem_addr", mem_addr, m_out ? m_addr : 32'd0);
        chk("m_mem_size", 32'(mem_size), m_out ? 32'(m_size) : 32'd0);
        chk("m_mem_wdata", mem_wdata, (m_out && m_st) ? m_wdata : 32'd0);
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    int sg[$];
    int nlg;

    initial begin
        repeat (2) @(posedge clk);
        half();
        chk("rst_cmd", 32'(mem_cmd), 32'd0);
        chk("rst_ld_valid", 32'(ld_valid), 32'd0);
        chk("rst_ld_data", ld_data, 32'd0);
        chk("rst_st_done", 32'(st_done), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        nxt();
        rst_n = 1;

        // Plain load, ack three cycles after grant
        ld_req = 1; ld_addr = 32'h100; ld_size = 3'd2;
        half(); chk("t2_grant", 32'(ld_grant), 32'd1); nxt();
        ld_req = 0;
        half(); chk("t2_cmd1", 32'(mem_cmd), 32'd1);
        chk("t2_addr", mem_addr, 32'h100); nxt();
        half(); chk("t2_cmd2", 32'(mem_cmd), 32'd1); nxt();
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        half(); chk("t2_cmd3", 32'(mem_cmd), 32'd1); nxt();
        mem_ack = 0; mem_rdata = 0;
        half(); chk("t2_valid", 32'(ld_valid), 32'd1);
        chk("t2_data", ld_data, 32'hDEADBEEF);
        chk("t2_cmd4", 32'(mem_cmd), 32'd0); nxt();
        half(); chk("t2_valid_off", 32'(ld_valid), 32'd0);
        chk("t2_data_hold", ld_data, 32'hDEADBEEF); nxt();

        // Plain store, ack immediately
        st_req = 1; st_addr = 32'h200; st_size = 3'd2; st_data = 32'h12345678;
        half(); chk("t3_grant", 32'(st_grant), 32'd1); nxt();
        st_req = 0; mem_ack = 1;
        half(); chk("t3_cmd", 32'(mem_cmd), 32'd2);
        chk("t3_wdata", mem_wdata, 32'h12345678);
        chk("t3_addr", mem_addr, 32'h200); nxt();
        mem_ack = 0;
        half(); chk("t3_done", 32'(st_done), 32'd1);
        chk("t3_cmd_off", 32'(mem_cmd), 32'd0); nxt();

        // Both requesters busy: stores forced through every 6 cycles
        ld_addr = 32'h300; st_addr = 32'h400; st_data = 32'hCAFE0000;
        nlg = 0;
        for (int c = 0; c < 21; c++) begin
            ld_req = (c < 19);
            st_req = (c < 17);
            mem_ack = 1;
            mem_rdata = 32'hA5A50000 + 32'(c);
            half();
            if (st_grant) sg.push_back(c);
            if (ld_grant) nlg++;
            nxt();
        end
        mem_ack = 0;
        chk("t4_nst", 32'(sg.size()), 32'd3);
        chk("t4_st0", 32'(sg.size() > 0 ? sg[0] : -1), 32'd4);
        chk("t4_st1", 32'(sg.size() > 1 ? sg[1] : -1), 32'd10);
        chk("t4_st2", 32'(sg.size() > 2 ? sg[2] : -1), 32'd16);
        chk("t4_nld", 32'(nlg), 32'd7);

        // Squash after grant, ack two cycles later
        ld_req = 1; ld_addr = 32'h500;
        half(); chk("t5_grant", 32'(ld_grant), 32'd1); nxt();
        ld_req = 0; squash = 1;
        half(); chk("t5_cmd1", 32'(mem_cmd), 32'd1); nxt();
        squash = 0;
        half(); chk("t5_drain_cmd", 32'(mem_cmd), 32'd1);
        chk("t5_drain_addr", mem_addr, 32'h500); nxt();
        mem_ack = 1; mem_rdata = 32'h11111111;
        half(); chk("t5_cmd3", 32'(mem_cmd), 32'd1); nxt();
        mem_ack = 0;
        half(); chk("t5_no_valid", 32'(ld_valid), 32'd0);
        chk("t5_cmd_off", 32'(mem_cmd), 32'd0);
        chk("t5_data_hold", ld_data, 32'hA5A50013); nxt();

        // Squash coinciding with ack
        ld_req = 1; ld_addr = 32'h600;
        half(); chk("t5b_grant", 32'(ld_grant), 32'd1); nxt();
        ld_req = 0; squash = 1; mem_ack = 1; mem_rdata = 32'h22222222;
        half(); nxt();
        squash = 0; mem_ack = 0;
        half(); chk("t5b_no_valid", 32'(ld_valid), 32'd0);
        chk("t5b_cmd_off", 32'(mem_cmd), 32'd0);
        chk("t5b_data_hold", ld_data, 32'hA5A50013); nxt();

        // Squash in IDLE hands the port to the store
        squash = 1; ld_req = 1; st_req = 1; st_addr = 32'h700; st_data = 32'h77;
        half(); chk("t6_st_grant", 32'(st_grant), 32'd1);
        chk("t6_no_ld_grant", 32'(ld_grant), 32'd0); nxt();
        squash = 0; st_req = 0; mem_ack = 1;
        half(); chk("t6_cmd", 32'(mem_cmd), 32'd2);
        chk("t6_busy_no_grant", 32'(ld_grant), 32'd0); nxt();
        mem_ack = 0;
        half(); chk("t6_done", 32'(st_done), 32'd1);
        chk("t6_ld_grant", 32'(ld_grant), 32'd1); nxt();
        ld_req = 0; mem_ack = 1; mem_rdata = 32'h66;
        half(); nxt();
        mem_ack = 0;
        half(); chk("t6_valid", 32'(ld_valid), 32'd1);
        chk("t6_data", ld_data, 32'h66); nxt();

        // Reset while a load is in flight
        ld_req = 1; ld_addr = 32'h800;
        half(); chk("t1_grant", 32'(ld_grant), 32'd1); nxt();
        ld_req = 0; rst_n = 0;
        half(); chk("t1_cmd", 32'(mem_cmd), 32'd0);
        chk("t1_addr", mem_addr, 32'd0);
        chk("t1_data", ld_data, 32'd0); nxt();
        rst_n = 1; mem_ack = 1; mem_rdata = 32'h99;
        half(); chk("t1_no_valid", 32'(ld_valid), 32'd0); nxt();
        mem_ack = 0;
        half(); chk("t1_no_valid2", 32'(ld_valid), 32'd0); nxt();
        ld_req = 1; ld_addr = 32'h900;
        half(); chk("t1_regrant", 32'(ld_grant), 32'd1); nxt();
        ld_req = 0; mem_ack = 1; mem_rdata = 32'hBB;
        half(); chk("t1_addr2", mem_addr, 32'h900); nxt();
        mem_ack = 0;
        half(); chk("t1_valid", 32'(ld_valid), 32'd1);
        chk("t1_data2", ld_data, 32'hBB); nxt();

        repeat (2) nxt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
